// File: rtl/lsu_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_ctrl_pkg
// Brief    : Shared widths, RV32 load/store funct3 codes and FSM encoding
// Revision : 1.0 - initial release
// ============================================================================
package lsu_bus_ctrl_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Store lane replication/strobes and load shift/extension
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_bus_ctrl_pkg::*;
(
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata_ext
);

    logic [XLEN-1:0] w_shifted;

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

    // Zero fill from the right shift means a misaligned access never wraps lanes
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_rdata_ext = w_shifted;
        case (i_funct3)
            F3_B:    o_rdata_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_rdata_ext = {24'd0, w_shifted[7:0]};
            F3_H:    o_rdata_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_rdata_ext = {16'd0, w_shifted[15:0]};
            default: o_rdata_ext = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_bus_ctrl
// Brief    : Multi-cycle load/store unit driving a split request/response bus.
//            Optional macro LSU_MISALIGN_CHECK_EN adds o_misalign trapping.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_bus_ctrl
    import lsu_bus_ctrl_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [2:0]      i_funct3,
    input  logic            i_load_en,
    input  logic            i_store_en,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_lsu_res,
    output logic            o_load_en,
    output logic            o_bus_err,
    output logic            o_mem_req_valid,
    input  logic            i_mem_req_ready,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [3:0]      o_mem_wstrb,
    input  logic            i_mem_rsp_valid,
    output logic            o_mem_rsp_ready,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_mem_rsp_err
`ifdef LSU_MISALIGN_CHECK_EN
    ,
    output logic            o_misalign
`endif
);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_funct3;
    logic            r_load;
    logic            r_store;
    logic [XLEN-1:0] r_lsu_res;
    logic            r_load_en;
    logic            r_bus_err;

    logic [3:0]      w_wstrb;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_res;
    logic            w_mem_op;
    logic            w_misalign;

    if (RESET_PC_UNUSED != 0) begin : g_reset_pc_reserved
    end

    lsu_align u_align (
        .i_addr_lo   (r_addr[1:0]),
        .i_funct3    (r_funct3),
        .i_wdata     (r_wdata),
        .i_rdata     (i_mem_rdata),
        .o_wstrb     (w_wstrb),
        .o_wdata     (w_wdata),
        .o_rdata_ext (w_load_res)
    );

    assign w_mem_op = i_load_en | i_store_en;

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_misalign;

    // funct3[1:0]: 00 byte, 01 halfword, 1x word
    assign w_misalign = w_mem_op &&
                        (((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                         (i_funct3[1] && (i_addr[1:0] != 2'b00)));
    assign o_misalign = r_misalign;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else if ((r_state == ST_IDLE) && i_valid) begin
            r_misalign <= w_misalign;
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_funct3  <= 3'd0;
            r_load    <= 1'b0;
            r_store   <= 1'b0;
            r_lsu_res <= '0;
            r_load_en <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_addr    <= i_addr;
                        r_wdata   <= i_wdata;
                        r_funct3  <= i_funct3;
                        r_load    <= i_load_en;
                        // A load wins when both flags are raised
                        r_store   <= i_store_en & ~i_load_en;
                        r_load_en <= i_load_en;
                        r_lsu_res <= '0;
                        r_bus_err <= 1'b0;
                        if (w_mem_op && !w_misalign) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_mem_rsp_valid) begin
                        r_bus_err <= i_mem_rsp_err;
                        r_lsu_res <= (r_load && !i_mem_rsp_err) ? w_load_res : '0;
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready         = (r_state == ST_IDLE);
    assign o_valid         = (r_state == ST_DONE);
    assign o_mem_req_valid = (r_state == ST_REQ);
    assign o_mem_rsp_ready = (r_state == ST_RESP);

    assign o_mem_addr  = {r_addr[XLEN-1:2], 2'b00};
    assign o_mem_wen   = r_store;
    assign o_mem_wdata = w_wdata;
    assign o_mem_wstrb = r_store ? w_wstrb : 4'b0000;

    assign o_lsu_res = r_lsu_res;
    assign o_load_en = r_load_en;
    assign o_bus_err = r_bus_err;

endmodule
`default_nettype wire
